// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: forwarding/FSM types, writeback encoding and the forwarding priority helper
package cpu_ctrl_pkg;
  typedef enum logic [1:0] {FWD_REG = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10} fwd_sel_e;
  typedef enum logic {S_RUN, S_MEM_WAIT} hz_state_e;
  localparam logic [1:0] WB_MEM = 2'b00;
  // MEM is the younger producer, so it wins over WB; x0 is never forwarded
  function automatic fwd_sel_e fwd_pick(input logic [4:0] rs, input logic [4:0] rd_mem, input logic we_mem,
                                        input logic [4:0] rd_wb, input logic we_wb);
    return (we_mem && rd_mem != 5'd0 && rs == rd_mem) ? FWD_MEM :
           (we_wb && rd_wb != 5'd0 && rs == rd_wb) ? FWD_WB : FWD_REG;
  endfunction
endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: combinational EX operand forwarding selects for rs1 and rs2
//   i_rs1/i_rs2       EX source registers
//   i_rd_mem/i_we_mem MEM destination and write enable
//   i_rd_wb/i_we_wb   WB destination and write enable
//   o_asel/o_bsel     forward selects for rs1/rs2
module fwd_unit
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] i_rs1,
  input  logic [4:0] i_rs2,
  input  logic [4:0] i_rd_mem,
  input  logic       i_we_mem,
  input  logic [4:0] i_rd_wb,
  input  logic       i_we_wb,
  output fwd_sel_e   o_asel,
  output fwd_sel_e   o_bsel
);
  assign o_asel = fwd_pick(i_rs1, i_rd_mem, i_we_mem, i_rd_wb, i_we_wb);
  assign o_bsel = fwd_pick(i_rs2, i_rd_mem, i_we_mem, i_rd_wb, i_we_wb);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline sequencer (forwarding, load-use stall, branch flush, D-cache freeze)
//   inputs : ID/EX/MEM/WB register ids and write enables, EX branch redirect, D-cache valid/ready
//   outputs: Asel/Bsel forward selects, per-stage enables and flushes,
//            saturating stall/flush counters, sticky wait-timeout error
module hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 256,
  parameter int CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       rs1_id_i,
  input  logic [4:0]       rs2_id_i,
  input  logic             use_rs1_id_i,
  input  logic             use_rs2_id_i,
  input  logic [4:0]       rs1_ex_i,
  input  logic [4:0]       rs2_ex_i,
  input  logic [4:0]       rsW_ex_i,
  input  logic             RegWEn_ex_i,
  input  logic [1:0]       WBSel_ex_i,
  input  logic [4:0]       rsW_mem_i,
  input  logic             RegWEn_mem_i,
  input  logic [4:0]       rsW_wb_i,
  input  logic             RegWEn_wb_i,
  input  logic             br_taken_ex_i,
  input  logic             Valid_cpu2cache_mem_i,
  input  logic             cache_ready_i,
  output fwd_sel_e         Asel_haz_o,
  output fwd_sel_e         Bsel_haz_o,
  output logic             pc_en_o,
  output logic             ifid_en_o,
  output logic             ifid_flush_o,
  output logic             idex_en_o,
  output logic             idex_flush_o,
  output logic             exmem_en_o,
  output logic             memwb_en_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             err_timeout_o
);
  localparam int WW = $clog2(WAIT_TIMEOUT + 1);
  hz_state_e        r_state;
  logic             r_live;
  logic [WW-1:0]    r_wait_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             r_err;
  logic [WW-1:0]    w_wait_nxt;
  logic             w_freeze;
  logic             w_run;
  logic             w_lu;
  logic             w_br;
  logic             w_stall;
  fwd_sel_e         w_asel;
  fwd_sel_e         w_bsel;

  fwd_unit u_fwd (
    .i_rs1   (rs1_ex_i),
    .i_rs2   (rs2_ex_i),
    .i_rd_mem(rsW_mem_i),
    .i_we_mem(RegWEn_mem_i),
    .i_rd_wb (rsW_wb_i),
    .i_we_wb (RegWEn_wb_i),
    .o_asel  (w_asel),
    .o_bsel  (w_bsel)
  );

  // r_live is low from reset until the first clock edge after release, forcing all outputs idle
  assign w_freeze = r_live & ((r_state == S_RUN) ? (Valid_cpu2cache_mem_i & ~cache_ready_i) : ~cache_ready_i);
  assign w_run    = r_live & ~w_freeze;
  assign w_lu     = RegWEn_ex_i && WBSel_ex_i == WB_MEM && rsW_ex_i != 5'd0 &&
                    ((use_rs1_id_i && rs1_id_i == rsW_ex_i) || (use_rs2_id_i && rs2_id_i == rsW_ex_i));
  assign w_br     = w_run & br_taken_ex_i;
  assign w_stall  = w_run & ~br_taken_ex_i & w_lu;
  assign w_wait_nxt = (r_wait_cnt == WW'(WAIT_TIMEOUT)) ? r_wait_cnt : r_wait_cnt + 1'b1;

  assign Asel_haz_o    = r_live ? w_asel : FWD_REG;
  assign Bsel_haz_o    = r_live ? w_bsel : FWD_REG;
  assign pc_en_o       = w_run & ~w_stall;
  assign ifid_en_o     = w_run & ~w_stall;
  assign ifid_flush_o  = w_br;
  assign idex_en_o     = w_run;
  assign idex_flush_o  = w_br | w_stall;
  assign exmem_en_o    = w_run;
  assign memwb_en_o    = w_run;
  assign stall_cnt_o   = r_stall_cnt;
  assign flush_cnt_o   = r_flush_cnt;
  assign err_timeout_o = r_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_RUN;
      r_live      <= 1'b0;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (r_live) begin
        r_state <= (r_state == S_RUN) ? ((Valid_cpu2cache_mem_i && !cache_ready_i) ? S_MEM_WAIT : S_RUN)
                                      : (cache_ready_i ? S_RUN : S_MEM_WAIT);
        r_wait_cnt <= (r_state == S_MEM_WAIT) ? w_wait_nxt : '0;
        if (r_state == S_MEM_WAIT && w_wait_nxt == WW'(WAIT_TIMEOUT)) r_err <= 1'b1;
        if (!pc_en_o && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
        if (w_br && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven and sequenced checks of hazard_ctrl
module tb_hazard_ctrl;
  localparam logic [6:0] C_RUN = 7'b1101011;
  localparam logic [6:0] C_BR  = 7'b1111111;
  localparam logic [6:0] C_STL = 7'b0001111;
  localparam logic [6:0] C_FRZ = 7'b0000000;

  typedef struct {
    logic [4:0] rs1_ex, rs2_ex, rsw_mem;
    logic       we_mem;
    logic [4:0] rsw_wb;
    logic       we_wb;
    logic [4:0] rs1_id, rs2_id;
    logic       use1, use2;
    logic [4:0] rsw_ex;
    logic       we_ex;
    logic [1:0] wbsel;
    logic       br;
    logic [1:0] ea, eb;
    logic [6:0] ectl;
  } vec_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rsw_ex, rsw_mem, rsw_wb;
  logic use1, use2, we_ex, we_mem, we_wb, br, valid, ready;
  logic [1:0] wbsel;
  logic [1:0] asel, bsel;
  logic pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, memwb_en, err;
  logic [31:0] stall_cnt, flush_cnt;
  logic [6:0] ctl;
  int checks = 0;
  int failures = 0;
  int exp_stall = 0;
  int exp_flush = 0;
  vec_t v [13];

  assign ctl = {pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, memwb_en};

  always #5 clk = ~clk;

  hazard_ctrl #(.WAIT_TIMEOUT(4), .CNT_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .rs1_id_i(rs1_id), .rs2_id_i(rs2_id), .use_rs1_id_i(use1), .use_rs2_id_i(use2),
    .rs1_ex_i(rs1_ex), .rs2_ex_i(rs2_ex), .rsW_ex_i(rsw_ex), .RegWEn_ex_i(we_ex), .WBSel_ex_i(wbsel),
    .rsW_mem_i(rsw_mem), .RegWEn_mem_i(we_mem), .rsW_wb_i(rsw_wb), .RegWEn_wb_i(we_wb),
    .br_taken_ex_i(br), .Valid_cpu2cache_mem_i(valid), .cache_ready_i(ready),
    .Asel_haz_o(asel), .Bsel_haz_o(bsel), .pc_en_o(pc_en),
    .ifid_en_o(ifid_en), .ifid_flush_o(ifid_fl), .idex_en_o(idex_en), .idex_flush_o(idex_fl),
    .exmem_en_o(exmem_en), .memwb_en_o(memwb_en),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .err_timeout_o(err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    {rs1_id, rs2_id, rs1_ex, rs2_ex, rsw_ex, rsw_mem, rsw_wb} = '0;
    {use1, use2, we_ex, we_mem, we_wb, br, valid, ready} = '0;
    wbsel = 2'b10;
  endtask

  task automatic apply(input vec_t t);
    rs1_ex = t.rs1_ex; rs2_ex = t.rs2_ex; rsw_mem = t.rsw_mem; we_mem = t.we_mem;
    rsw_wb = t.rsw_wb; we_wb = t.we_wb; rs1_id = t.rs1_id; rs2_id = t.rs2_id;
    use1 = t.use1; use2 = t.use2; rsw_ex = t.rsw_ex; we_ex = t.we_ex; wbsel = t.wbsel; br = t.br;
  endtask

  task automatic chk_cnt(input string nm);
    chk({nm, "_stall_cnt"}, stall_cnt, exp_stall);
    chk({nm, "_flush_cnt"}, flush_cnt, exp_flush);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    v[0]  = '{5'd5, 5'd0, 5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b10, 1'b0, 2'b01, 2'b00, C_RUN};
    v[1]  = '{5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b10, 1'b0, 2'b00, 2'b00, C_RUN};
    v[2]  = '{5'd3, 5'd3, 5'd4, 1'b1, 5'd3, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b10, 1'b0, 2'b10, 2'b10, C_RUN};
    v[3]  = '{5'd6, 5'd7, 5'd7, 1'b1, 5'd6, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b10, 1'b0, 2'b00, 2'b01, C_RUN};
    v[4]  = '{5'd9, 5'd0, 5'd9, 1'b0, 5'd9, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b10, 1'b0, 2'b10, 2'b00, C_RUN};
    v[5]  = '{5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, C_STL};
    v[6]  = '{5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd3, 1'b0, 1'b1, 5'd7, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, C_RUN};
    v[7]  = '{5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 2'b01, 1'b0, 2'b00, 2'b00, C_RUN};
    v[8]  = '{5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, C_RUN};
    v[9]  = '{5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b10, 1'b1, 2'b00, 2'b00, C_BR};
    v[10] = '{5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 2'b00, 1'b1, 2'b00, 2'b00, C_BR};
    v[11] = '{5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd12, 1'b0, 1'b1, 5'd12, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, C_STL};
    v[12] = '{5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, C_RUN};
    clr();
    // reset state, held through release until the first edge
    #1;
    chk("rst_ctl", ctl, C_FRZ);
    chk("rst_asel", asel, 2'b00);
    chk("rst_err", err, 1'b0);
    chk_cnt("rst");
    v[0].br = v[0].br;
    apply(v[0]);
    #1;
    chk("rst_asel_fwd_inputs", asel, 2'b00);
    clr();
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    #1;
    chk("release_hold_ctl", ctl, C_FRZ);
    // table vectors
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      apply(v[i]);
      #1;
      chk($sformatf("vec%0d_asel", i), asel, v[i].ea);
      chk($sformatf("vec%0d_bsel", i), bsel, v[i].eb);
      chk($sformatf("vec%0d_ctl", i), ctl, v[i].ectl);
      if (!v[i].ectl[6]) exp_stall++;
      if (v[i].ectl[4]) exp_flush++;
    end
    @(negedge clk);
    clr();
    #1;
    chk_cnt("table");
    // load-use: lw x7 in EX, ID reads rs2=x7
    rsw_ex = 5'd7; we_ex = 1'b1; wbsel = 2'b00; rs2_id = 5'd7; use2 = 1'b1;
    #1;
    chk("lu_a_ctl", ctl, C_STL);
    exp_stall++;
    @(negedge clk);
    clr();
    rsw_mem = 5'd7; we_mem = 1'b1; wbsel = 2'b00; rs2_id = 5'd7; use2 = 1'b1;
    #1;
    chk("lu_b_ctl", ctl, C_RUN);
    @(negedge clk);
    clr();
    rs2_ex = 5'd7; rsw_wb = 5'd7; we_wb = 1'b1;
    #1;
    chk("lu_c_bsel", bsel, 2'b10);
    chk("lu_c_ctl", ctl, C_RUN);
    // cache hit in the same cycle: no stall
    @(negedge clk);
    clr();
    valid = 1'b1; ready = 1'b1;
    #1;
    chk("hit_ctl", ctl, C_RUN);
    @(negedge clk);
    chk_cnt("lu");
    // cache miss for 5 cycles with a pending branch, released on ready
    valid = 1'b1; ready = 1'b0; br = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("miss%0d_ctl", k), ctl, C_FRZ);
      exp_stall++;
      @(negedge clk);
    end
    ready = 1'b1;
    #1;
    chk("miss_ready_ctl", ctl, C_BR);
    exp_flush++;
    @(negedge clk);
    clr();
    #1;
    chk("miss_after_ctl", ctl, C_RUN);
    chk_cnt("miss");
    // reset mid-run, then timeout sequence
    rst_ni = 1'b0;
    exp_stall = 0; exp_flush = 0;
    #1;
    chk_cnt("rst2");
    chk("rst2_err", err, 1'b0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    valid = 1'b1; ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("tmo%0d_err", k), err, k >= 5);
      chk($sformatf("tmo%0d_ctl", k), ctl, C_FRZ);
    end
    // reset asserted mid-wait takes effect immediately
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rst3_ctl", ctl, C_FRZ);
    chk("rst3_err", err, 1'b0);
    chk("rst3_stall_cnt", stall_cnt, 32'd0);
    @(negedge clk);
    valid = 1'b0;
    rst_ni = 1'b1;
    @(negedge clk);
    #1;
    chk("rst3_run_ctl", ctl, C_RUN);
    @(negedge clk);
    #1;
    chk("rst3_run2_ctl", ctl, C_RUN);
    chk("rst3_run_stall_cnt", stall_cnt, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
